// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: FSM encoding, winner codes, win-line masks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ttt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_COMMIT = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int CELLS = 9;

  // Index 0..2 rows, 3..5 columns, 6..7 diagonals; bit i = cell i, row-major.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'h054,  // diagonal 2,4,6
    9'h111,  // diagonal 0,4,8
    9'h124,  // column 2,5,8
    9'h092,  // column 1,4,7
    9'h049,  // column 0,3,6
    9'h1C0,  // row 6,7,8
    9'h038,  // row 3,4,5
    9'h007   // row 0,1,2
  };

endpackage

// File: rtl/board_state_win_detect.sv
// Flags a completed row, column or diagonal on one player's occupancy board.
// Latency: combinational.
// Backpressure: none.
module win_detect
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic       win
);

  // OR of all eight full-line matches
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/board_state.sv
// Tic-tac-toe board: validates button presses, commits marks, detects win/draw.
// Latency: press edge -> accept/reject visible 2 cycles later, result 3 cycles later.
// Backpressure: none; presses outside IDLE/DONE are dropped. Option: BOARD_STATE_RESTART_EN adds new_game.
module board_state
  import ttt_pkg::*;
#(
  parameter bit FIRST_MARK_X = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       enter,
  input  logic [3:0] cell_sel,
  input  logic       player_turn,
`ifdef BOARD_STATE_RESTART_EN
  input  logic       new_game,
`endif
  output logic       move_accept,
  output logic       move_reject,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
);

  state_t     state;
  logic       enter_q;
  logic       armed;      // enter has been seen low since reset
  logic [3:0] cell_q;
  logic       turn_q;
  logic       mark_x_q;
  logic       press;
  logic       restart;
  logic [8:0] cell_mask;
  logic       cell_bad;
  logic [8:0] mover_board;
  logic       line_win;

  assign press = enter & ~enter_q & armed;

`ifdef BOARD_STATE_RESTART_EN
  assign restart = new_game & ((state == ST_IDLE) | (state == ST_DONE));
`else
  assign restart = 1'b0;
`endif

  // Out-of-range indices yield an empty mask, which is then treated as illegal.
  assign cell_mask   = (cell_q < 4'(CELLS)) ? (9'd1 << cell_q) : 9'd0;
  assign cell_bad    = (cell_mask == 9'd0) | (|((board_x | board_o) & cell_mask));
  assign mover_board = mark_x_q ? board_x : board_o;

  win_detect u_win_detect (
    .board (mover_board),
    .win   (line_win)
  );

  // Move FSM; the win/draw decision is registered at the end of COMMIT so it
  // is already visible while the FSM sits in EVAL.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= ST_IDLE;
      enter_q     <= 1'b0;
      armed       <= 1'b0;
      cell_q      <= 4'd0;
      turn_q      <= 1'b0;
      mark_x_q    <= 1'b0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      board_x     <= 9'd0;
      board_o     <= 9'd0;
      move_count  <= 4'd0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      enter_q     <= enter;
      armed       <= armed | ~enter;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      if (restart) begin
        board_x    <= 9'd0;
        board_o    <= 9'd0;
        move_count <= 4'd0;
        game_over  <= 1'b0;
        winner     <= WIN_NONE;
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (press) begin
              cell_q   <= cell_sel;
              turn_q   <= player_turn;
              mark_x_q <= ~((~player_turn) ^ FIRST_MARK_X);
              state    <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (cell_bad) begin
              move_reject <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              move_accept <= 1'b1;
              if (mark_x_q) board_x <= board_x | cell_mask;
              else          board_o <= board_o | cell_mask;
              move_count  <= move_count + 4'd1;
              state       <= ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            // Line check first so a winning ninth move never reads as a draw.
            if (line_win) begin
              winner    <= turn_q ? WIN_P2 : WIN_P1;
              game_over <= 1'b1;
            end else if (move_count == 4'(CELLS)) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
            end
            state <= ST_EVAL;
          end
          ST_EVAL: begin
            state <= game_over ? ST_DONE : ST_IDLE;
          end
          ST_DONE: begin
            if (press) move_reject <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: legal/illegal moves, win, draw, reset abort.
// Latency: checks pulses at exact cycles after each press.
// Backpressure: n/a.
module tb_board_state;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       enter;
  logic [3:0] cell_sel;
  logic       player_turn;
  logic       move_accept;
  logic       move_reject;
  logic [8:0] board_x;
  logic [8:0] board_o;
  logic [3:0] move_count;
  logic       game_over;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  // Per-press observation window (samples 1..4 after the press edge)
  int         acc_n, rej_n, both_n, acc_at, rej_at;
  logic [1:0] win_s2, win_s3;

  board_state #(.FIRST_MARK_X(1'b1)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .enter       (enter),
    .cell_sel    (cell_sel),
    .player_turn (player_turn),
    .move_accept (move_accept),
    .move_reject (move_reject),
    .board_x     (board_x),
    .board_o     (board_o),
    .move_count  (move_count),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    enter = 1'b0;
    cell_sel = 4'd0;
    player_turn = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  // One press on cell c by turn t, enter high for a single cycle.
  task automatic press(input logic [3:0] c, input logic t);
    acc_n = 0; rej_n = 0; both_n = 0; acc_at = 0; rej_at = 0;
    win_s2 = 2'b00; win_s3 = 2'b00;
    @(negedge clk);
    cell_sel = c;
    player_turn = t;
    enter = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) enter = 1'b0;
      if (move_accept) begin acc_n++; if (acc_at == 0) acc_at = k; end
      if (move_reject) begin rej_n++; if (rej_at == 0) rej_at = k; end
      if (move_accept && move_reject) both_n++;
      if (k == 2) win_s2 = winner;
      if (k == 3) win_s3 = winner;
    end
  endtask

  // Legal move expectation: single accept in cycle 2, no reject.
  task automatic legal(input string tag, input logic [3:0] c, input logic t);
    press(c, t);
    chk({tag, "_acc_at"}, acc_at, 2);
    chk({tag, "_acc_n"}, acc_n, 1);
    chk({tag, "_rej_n"}, rej_n, 0);
  endtask

  typedef struct { logic [3:0] c; logic t; } mv_t;
  mv_t draw_seq [9];
  mv_t win9_seq [9];

  initial begin
    draw_seq = '{'{4'd0,1'b0}, '{4'd1,1'b1}, '{4'd2,1'b0}, '{4'd4,1'b1}, '{4'd3,1'b0},
                 '{4'd5,1'b1}, '{4'd7,1'b0}, '{4'd6,1'b1}, '{4'd8,1'b0}};
    win9_seq = '{'{4'd0,1'b0}, '{4'd1,1'b1}, '{4'd2,1'b0}, '{4'd4,1'b1}, '{4'd3,1'b0},
                 '{4'd5,1'b1}, '{4'd7,1'b0}, '{4'd8,1'b1}, '{4'd6,1'b0}};

    // Reset values
    clr_n = 1'b0; enter = 1'b0; cell_sel = 4'd0; player_turn = 1'b0;
    #12;
    chk("rst_board_x", board_x, 9'h000);
    chk("rst_board_o", board_o, 9'h000);
    chk("rst_count", move_count, 0);
    chk("rst_flags", {game_over, winner, move_accept, move_reject}, 5'b0);
    do_reset();

    // First move: X on centre
    legal("m1", 4'd4, 1'b0);
    chk("m1_board_x", board_x, 9'h010);
    chk("m1_board_o", board_o, 9'h000);
    chk("m1_count", move_count, 1);

    // Occupied cell
    press(4'd4, 1'b1);
    chk("occ_rej_at", rej_at, 2);
    chk("occ_acc_n", acc_n, 0);
    chk("occ_boards", {board_x, board_o}, {9'h010, 9'h000});
    chk("occ_count", move_count, 1);

    // Out-of-range cells
    press(4'd9, 1'b1);
    chk("c9_rej_at", rej_at, 2);
    chk("c9_acc_n", acc_n, 0);
    press(4'd15, 1'b1);
    chk("c15_rej_at", rej_at, 2);
    chk("c15_acc_n", acc_n, 0);
    chk("oob_count", move_count, 1);
    chk("oob_boards", {board_x, board_o}, {9'h010, 9'h000});

    // Player 1 completes 0,4,8
    legal("m2", 4'd1, 1'b1);
    legal("m3", 4'd0, 1'b0);
    legal("m4", 4'd2, 1'b1);
    chk("m4_board_o", board_o, 9'h006);
    chk("m4_game_over", game_over, 0);
    legal("m5", 4'd8, 1'b0);
    chk("diag_win_cycle2", win_s2, 2'b00);
    chk("diag_win_cycle3", win_s3, 2'b01);
    chk("diag_game_over", game_over, 1);
    chk("diag_board_x", board_x, 9'h111);
    chk("diag_count", move_count, 5);

    // Press after game end
    press(4'd5, 1'b1);
    chk("done_rej_at", rej_at, 1);
    chk("done_rej_n", rej_n, 1);
    chk("done_acc_n", acc_n, 0);
    chk("done_hold", {board_x, board_o, winner, game_over}, {9'h111, 9'h006, 2'b01, 1'b1});

    // Full-board draw
    do_reset();
    for (int i = 0; i < 9; i++) press(draw_seq[i].c, draw_seq[i].t);
    chk("draw_board_x", board_x, 9'h18D);
    chk("draw_board_o", board_o, 9'h072);
    chk("draw_count", move_count, 9);
    chk("draw_winner", winner, 2'b11);
    chk("draw_game_over", game_over, 1);

    // Ninth move completes a line: win, not draw
    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(win9_seq[i].c, win9_seq[i].t);
      if (i == 7) chk("w9_pre_winner", winner, 2'b00);
      checks++;
      if (both_n != 0) begin
        errors++;
        $display("FAIL w9_excl got %0d expected 0", both_n);
      end
    end
    chk("w9_board_x", board_x, 9'h0CD);
    chk("w9_board_o", board_o, 9'h132);
    chk("w9_count", move_count, 9);
    chk("w9_winner", winner, 2'b01);

    // Player 2 win: O completes row 3,4,5
    do_reset();
    legal("p2a", 4'd0, 1'b0);
    legal("p2b", 4'd3, 1'b1);
    legal("p2c", 4'd1, 1'b0);
    legal("p2d", 4'd4, 1'b1);
    legal("p2e", 4'd8, 1'b0);
    legal("p2f", 4'd5, 1'b1);
    chk("p2_winner", winner, 2'b10);
    chk("p2_board_o", board_o, 9'h038);

    // Reset while in COMMIT with enter held high
    do_reset();
    @(negedge clk);
    cell_sel = 4'd0; player_turn = 1'b0; enter = 1'b1;
    @(negedge clk);            // CHECK
    @(negedge clk);            // COMMIT, accept high
    chk("abort_acc_seen", move_accept, 1);
    clr_n = 1'b0;
    #1;
    chk("abort_zero", {board_x, board_o, move_count, game_over, winner, move_accept, move_reject},
        {9'h000, 9'h000, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0});
    @(negedge clk);
    clr_n = 1'b1;
    acc_n = 0; rej_n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (move_accept) acc_n++;
      if (move_reject) rej_n++;
    end
    chk("held_acc_n", acc_n, 0);
    chk("held_rej_n", rej_n, 0);
    chk("held_board_x", board_x, 9'h000);
    enter = 1'b0;
    @(negedge clk);
    legal("rearm", 4'd3, 1'b0);
    chk("rearm_board_x", board_x, 9'h008);
    chk("rearm_count", move_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 Parameter: FIRST_MARK_X, default 1, 1 = player 1 places X and player 2 places O; 0 = the reverse.
REQ-002 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Port: clr_n  in  1  reset; asynchronous, active-low.
REQ-004 Port: enter  in  1  debounced button level, synchronous to clk.
REQ-005 Port: cell_sel  in  4  target cell index 0..8, row-major, cell 0 at top-left.
REQ-006 Port: player_turn  in  1  current turn from the turn stage: 0 = player 1, 1 = player 2.
REQ-007 Port: move_accept  out  1  one-cycle pulse on a legal move; drives the turn stage's enter input.
REQ-008 Port: move_reject  out  1  one-cycle pulse on an illegal move.
REQ-009 Port: board_x  out  9  X occupancy, bit i = cell i.
REQ-010 Port: board_o  out  9  O occupancy, bit i = cell i.
REQ-011 Port: move_count  out  4  number of committed moves, 0..9.
REQ-012 Port: game_over  out  1  level; high once a win or draw is determined.
REQ-013 Port: winner  out  2  result: 00 none, 01 player 1, 10 player 2, 11 draw.

Function
REQ-014 FSM states: IDLE, CHECK, COMMIT, EVAL, DONE; all outputs registered.
REQ-015 Press detection: enter high with the previous registered enter low, in IDLE; cycle 0 latches cell_sel and player_turn and moves to CHECK.
REQ-016 CHECK (cycle 1), illegal move: cell_sel > 8, or the cell is already set in board_x or board_o.
  -> move_reject = 1 in cycle 2; return to IDLE; board and move_count unchanged.
REQ-017 CHECK, legal move -> COMMIT.
  -> In cycle 2: move_accept = 1 for exactly one cycle; the cell bit is set in the mover's board; move_count increments.
REQ-018 Mark selection: mover X when (latched player_turn == 0) XNOR FIRST_MARK_X; otherwise O.
REQ-019 EVAL (cycle 3): test the 8 win lines (3 rows, 3 columns, 2 diagonals) against the mover's board.
  -> Line complete: winner = 01 or 10 per the latched player_turn; game_over = 1; go to DONE.
  -> Else move_count == 9: winner = 11; game_over = 1; go to DONE.
  -> Else: return to IDLE.
REQ-020 Presses in CHECK, COMMIT or EVAL are ignored, with no pulse; enter held high produces one press only.
REQ-021 DONE: every press -> move_reject pulse; board, winner and game_over hold until reset, or until new_game per REQ-027.
REQ-022 Pulse exclusivity: move_accept and move_reject are never high in the same cycle; at most one of the two per press.
REQ-023 Win priority: a winning 9th move reports its player (01 or 10), never draw (11).

Reset
REQ-024 Reset values while clr_n = 0: state IDLE; board_x, board_o = 0; move_count = 0; winner = 00; game_over = 0; move_accept, move_reject = 0; enter history = 0.
REQ-025 Reset mid-move: assertion in any state aborts the move at once; no pulse is emitted after release.
REQ-026 After clr_n releases: enter already high does not count as a press until it has been seen low.

Configuration
REQ-027 With BOARD_STATE_RESTART_EN defined: input port new_game (1 bit) is added.
  -> new_game = 1 sampled in IDLE or DONE clears board, count, winner and game_over next cycle and enters IDLE.
  -> new_game takes priority over a simultaneous press.
  -> new_game is ignored in CHECK, COMMIT and EVAL.
REQ-028 Without BOARD_STATE_RESTART_EN: no new_game port; only clr_n restarts a game.

Structure
REQ-029 Shared package ttt_pkg holds: FSM state encoding, winner codes (NONE, P1, P2, DRAW), the 8 win-line 9-bit masks, and constant CELLS = 9.
REQ-030 Sub-module win_detect (combinational, 9-bit board in, 1-bit win out), instantiated once on the mover's board.

Verification
REQ-031 Reset, then player_turn = 0, press on cell 4 -> move_accept in cycle 2; board_x = 9'h010; move_count = 1.
REQ-032 Press on cell 4 again -> move_reject in cycle 2; board unchanged; no move_accept.
REQ-033 cell_sel = 9 or 15 -> move_reject; board and count unchanged.
REQ-034 Player 1 completes cells 0, 4, 8 -> winner = 01, game_over = 1 in cycle 3; next press -> move_reject.
REQ-035 Nine alternating legal moves, no line complete -> winner = 11 after the 9th move; the same sequence ending in a line on move 9 -> winner = 01.
REQ-036 Reset pulsed in COMMIT -> all outputs zero; enter held high through release gives no press until enter goes low then high.
